// File: rtl/div_ctrl.sv
// Iterative 32-bit integer divider controller (DIV/DIVU).
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// with sign fix-up applied when the result is loaded.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [31:0] r_a;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_trial;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Operand magnitudes, trial subtraction and signed fix-up of the final values.
  always_comb begin
    w_a_mag   = (signed_div && a[31]) ? (32'd0 - a) : a;
    w_b_mag   = (signed_div && b[31]) ? (32'd0 - b) : b;
    // Partial remainder shifted left with the next dividend bit, minus divisor.
    w_trial   = {r_rem, r_quo[31]} - {1'b0, r_div};
    w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;
  end

  // Control FSM, datapath registers and registered result/ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_a      <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (annul) begin
        // Flush wins over everything, including a same-cycle start.
        r_state <= ST_IDLE;
        r_cnt   <= 6'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_a     <= a;
              r_div   <= w_b_mag;
              r_quo   <= w_a_mag;
              r_rem   <= 32'd0;
              r_neg_q <= signed_div & (a[31] ^ b[31]);
              r_neg_r <= signed_div & a[31];
              r_zero  <= (b == 32'd0);
              r_cnt   <= 6'd0;
              r_state <= (b == 32'd0) ? ST_DONE : ST_RUN;
            end
          end
          ST_RUN: begin
            // r_quo doubles as the dividend shift register; quotient bits enter at LSB.
            if (!w_trial[32]) begin
              r_rem <= w_trial[31:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= {r_rem[30:0], r_quo[31]};
              r_quo <= {r_quo[30:0], 1'b0};
            end
            if (r_cnt == 6'd31) begin
              r_cnt   <= 6'd0;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          ST_DONE: begin
            r_result <= r_zero ? {r_a, 32'hFFFF_FFFF} : {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
          end
        endcase
      end
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    result = r_result;
    ready  = r_ready;
    busy   = (r_state != ST_IDLE);
  end

endmodule
